// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types for the instruction/data memory port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    // Which side owns the memory transaction being granted
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_streak_counter.sv
`default_nettype none
// ============================================================================
//  Module   : arb_streak_counter
//  Purpose  : Saturating count of consecutive data grants taken while a
//             fetch was waiting; clear has priority over increment.
//  Revision : 1.0  initial release
// ============================================================================
module arb_streak_counter #(
    parameter int MAX_COUNT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int                c_cnt_w = $clog2(MAX_COUNT + 1);
    localparam logic [c_cnt_w-1:0] c_max  = c_cnt_w'(MAX_COUNT);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;

    // Count up to the limit and hold there until cleared
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != c_max)) begin
            r_count <= r_count + c_one;
        end
    end

    assign sat_o = (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one memory port between instruction fetch and data
//             accesses. Data has priority, but a waiting fetch is granted
//             after MAX_D_STREAK consecutive data grants. A flushed fetch
//             still completes on the memory side but is silently dropped.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                i_valid_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic                i_ready_o,
    output logic [DATA_W-1:0]   i_rdata_o,
    input  logic                d_valid_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    output logic                d_ready_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    owner_t              w_grant_owner;
    logic                w_grant;
    logic                w_i_elig;
    logic                w_d_elig;
    logic                w_streak_sat;
    logic                w_streak_inc;
    logic                w_streak_clr;

    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W/8-1:0] r_mem_be;
    logic                r_i_ready;
    logic                r_d_ready;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_drop;

    // A requester is not eligible in its own ready cycle; flush masks fetch
    assign w_i_elig = i_valid_i && !flush_i && !r_i_ready;
    assign w_d_elig = d_valid_i && !r_d_ready;

    // Streak only grows while a fetch is actually being held off
    assign w_streak_inc = w_grant && (w_grant_owner == OWN_D) && i_valid_i;
    assign w_streak_clr = w_grant && ((w_grant_owner == OWN_I) || !i_valid_i);

    arb_streak_counter #(
        .MAX_COUNT (MAX_D_STREAK)
    ) u_streak (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_streak_inc),
        .clr_i (w_streak_clr),
        .sat_o (w_streak_sat)
    );

    // Arbitration in IDLE and next-state selection
    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        w_grant_owner = OWN_D;
        case (r_state)
            ARB_IDLE: begin
                if (w_i_elig || w_d_elig) begin
                    w_grant = 1'b1;
                    if (w_d_elig && !(w_i_elig && w_streak_sat)) begin
                        w_grant_owner = OWN_D;
                        w_state_nxt   = ARB_BUSY_D;
                    end else begin
                        w_grant_owner = OWN_I;
                        w_state_nxt   = ARB_BUSY_I;
                    end
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (mem_ack_i) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the granted payload and hold the request until acknowledged
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else if (w_grant) begin
            r_mem_req <= 1'b1;
            if (w_grant_owner == OWN_D) begin
                r_mem_we    <= d_we_i;
                r_mem_addr  <= d_addr_i;
                r_mem_wdata <= d_wdata_i;
                r_mem_be    <= d_be_i;
            end else begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= i_addr_i;
                r_mem_wdata <= '0;
                r_mem_be    <= '1;
            end
        end else if ((r_state != ARB_IDLE) && mem_ack_i) begin
            r_mem_req <= 1'b0;
        end
    end

    // Completion: capture read data, pulse ready, track dropped fetches
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            if ((r_state == ARB_BUSY_D) && mem_ack_i) begin
                r_d_rdata <= mem_rdata_i;
                r_d_ready <= 1'b1;
            end
            if (r_state == ARB_BUSY_I) begin
                if (mem_ack_i) begin
                    // A flush on the ack cycle itself also discards the word
                    if (!(r_drop || flush_i)) begin
                        r_i_rdata <= mem_rdata_i;
                        r_i_ready <= 1'b1;
                    end
                    r_drop <= 1'b0;
                end else if (flush_i) begin
                    r_drop <= 1'b1;
                end
            end
        end
    end

    assign i_ready_o   = r_i_ready;
    assign i_rdata_o   = r_i_rdata;
    assign d_ready_o   = r_d_ready;
    assign d_rdata_o   = r_d_rdata;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_be_o    = r_mem_be;
    assign busy_o      = (r_state != ARB_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Scoreboard bench for mem_port_arbiter with a behavioural
//             reference model and a randomised memory responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MAX_D = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        i_valid_i;
    logic [31:0] i_addr_i;
    logic        i_ready_o;
    logic [31:0] i_rdata_o;
    logic        d_valid_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_ready_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_D_STREAK (MAX_D)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .i_valid_i   (i_valid_i),
        .i_addr_i    (i_addr_i),
        .i_ready_o   (i_ready_o),
        .i_rdata_o   (i_rdata_o),
        .d_valid_i   (d_valid_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_be_i      (d_be_i),
        .d_ready_o   (d_ready_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Expected traffic
    req_t        exp_mem[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    // Reference model state
    bit          m_busy    = 0;
    bit          m_owner_d = 0;
    bit          m_drop    = 0;
    bit          m_i_rdy   = 0;
    bit          m_d_rdy   = 0;
    int          m_streak  = 0;
    logic [31:0] m_i_held  = '0;
    logic [31:0] m_d_held  = '0;

    // Stimulus knobs (percent probabilities)
    int i_prob = 0, d_prob = 0, flush_prob = 0, spur_prob = 0;
    int ack_fixed = 0, ack_max = 3;
    bit armed = 0;
    int ack_cnt = 0;

    task automatic fail_msg(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_errors++;
        $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) fail_msg(name, act, exp);
    endtask

    // Reference model: evaluated once per rising edge on the inputs the DUT sees
    task automatic model_step();
        bit ie, de, gd, nxt_i, nxt_d;
        nxt_i = 0;
        nxt_d = 0;
        if (rst_i) begin
            m_busy = 0; m_owner_d = 0; m_drop = 0; m_streak = 0;
            m_i_rdy = 0; m_d_rdy = 0; m_i_held = '0; m_d_held = '0;
            exp_mem.delete(); exp_i.delete(); exp_d.delete();
            return;
        end
        if (!m_busy) begin
            ie = i_valid_i && !flush_i && !m_i_rdy;
            de = d_valid_i && !m_d_rdy;
            if (ie || de) begin
                gd = de && !(ie && (m_streak == MAX_D));
                if (gd) begin
                    exp_mem.push_back('{we: d_we_i, addr: d_addr_i, wdata: d_wdata_i, be: d_be_i});
                    m_streak = i_valid_i ? ((m_streak < MAX_D) ? m_streak + 1 : MAX_D) : 0;
                end else begin
                    exp_mem.push_back('{we: 1'b0, addr: i_addr_i, wdata: 32'h0, be: 4'hF});
                    m_streak = 0;
                end
                m_owner_d = gd;
                m_busy    = 1;
            end
        end else if (mem_ack_i) begin
            m_busy = 0;
            if (m_owner_d) begin
                m_d_held = mem_rdata_i;
                exp_d.push_back(mem_rdata_i);
                nxt_d = 1;
            end else if (!(m_drop || flush_i)) begin
                m_i_held = mem_rdata_i;
                exp_i.push_back(mem_rdata_i);
                nxt_i = 1;
            end
            m_drop = 0;
        end else if (!m_owner_d && flush_i) begin
            m_drop = 1;
        end
        m_i_rdy = nxt_i;
        m_d_rdy = nxt_d;
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            model_step();
        end
    end

    // Requesters and memory responder, applied on the falling edge
    task automatic drive_step();
        if (i_valid_i && (i_ready_o || flush_i)) i_valid_i = 1'b0;
        if (!i_valid_i && ($urandom_range(99, 0) < i_prob)) begin
            i_valid_i = 1'b1;
            i_addr_i  = {$urandom} & 32'hFFFF_FFFC;
        end
        flush_i = ($urandom_range(99, 0) < flush_prob);

        if (d_valid_i && d_ready_o) d_valid_i = 1'b0;
        if (!d_valid_i && ($urandom_range(99, 0) < d_prob)) begin
            d_valid_i = 1'b1;
            d_we_i    = $urandom_range(1, 0) == 1;
            d_addr_i  = {$urandom} & 32'hFFFF_FFFC;
            d_wdata_i = $urandom;
            d_be_i    = 4'($urandom_range(15, 1));
        end

        if (mem_req_o && !mem_ack_i) begin
            if (!armed) begin
                armed   = 1;
                ack_cnt = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(ack_max, 0));
            end
            if (ack_cnt == 0) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = $urandom;
                armed       = 0;
            end else begin
                ack_cnt--;
            end
        end else begin
            mem_ack_i = 1'b0;
            if (!mem_req_o && ($urandom_range(99, 0) < spur_prob)) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = $urandom;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk_i);
            drive_step();
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard away from the edge
    initial begin
        bit   prev_req = 0;
        bit   have_cur = 0;
        req_t cur;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_req = 0;
                have_cur = 0;
                continue;
            end
            check("busy_o", busy_o, m_busy);
            check("mem_req_o", mem_req_o, m_busy);
            if (mem_req_o && !prev_req) begin
                n_checks++;
                if (exp_mem.size() == 0) begin
                    fail_msg("unexpected_mem_req", mem_addr_o, 0);
                    have_cur = 0;
                end else begin
                    cur      = exp_mem.pop_front();
                    have_cur = 1;
                end
            end
            if (mem_req_o && have_cur) begin
                check("mem_we_o", mem_we_o, cur.we);
                check("mem_addr_o", mem_addr_o, cur.addr);
                check("mem_wdata_o", mem_wdata_o, cur.wdata);
                check("mem_be_o", mem_be_o, cur.be);
            end
            check("i_ready_o", i_ready_o, m_i_rdy);
            check("d_ready_o", d_ready_o, m_d_rdy);
            if (i_ready_o) begin
                if (exp_i.size() == 0) begin
                    n_checks++;
                    fail_msg("unexpected_i_ready", i_rdata_o, 0);
                end else begin
                    check("i_rdata_at_ready", i_rdata_o, exp_i.pop_front());
                end
            end
            if (d_ready_o) begin
                if (exp_d.size() == 0) begin
                    n_checks++;
                    fail_msg("unexpected_d_ready", d_rdata_o, 0);
                end else begin
                    check("d_rdata_at_ready", d_rdata_o, exp_d.pop_front());
                end
            end
            check("i_rdata_held", i_rdata_o, m_i_held);
            check("d_rdata_held", d_rdata_o, m_d_held);
            prev_req = mem_req_o;
        end
    end

    // Directed scenarios followed by randomised traffic
    initial begin
        logic [31:0] saved;
        bit          hit;
        rst_i = 1'b1; flush_i = 1'b0; i_valid_i = 1'b0; i_addr_i = '0;
        d_valid_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;

        repeat (3) @(negedge clk_i);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_i_ready", i_ready_o, 0);
        check("rst_d_ready", d_ready_o, 0);
        check("rst_i_rdata", i_rdata_o, 0);
        check("rst_d_rdata", d_rdata_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        rst_i = 1'b0;

        // Lone fetch, ack in the third request cycle
        ack_fixed = 2;
        @(negedge clk_i);
        i_valid_i = 1'b1; i_addr_i = 32'hBFC0_0000;
        run_cycles(10);

        // Simultaneous fetch and store: data must win
        ack_fixed = 1;
        @(negedge clk_i);
        i_valid_i = 1'b1; i_addr_i = 32'h0000_0300;
        d_valid_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_0100;
        d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'hF;
        run_cycles(12);

        // Fetch held with back-to-back data, single-cycle acks
        ack_fixed = 0; i_prob = 100; d_prob = 100;
        run_cycles(60);
        i_prob = 0; d_prob = 0;
        run_cycles(20);

        // Flush during an in-flight fetch
        ack_fixed = 4;
        @(negedge clk_i);
        i_valid_i = 1'b1; i_addr_i = 32'h0000_0700;
        hit = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            drive_step();
            if (m_busy && !m_owner_d) begin
                hit = 1;
                break;
            end
        end
        check("wait_fetch_grant", hit, 1);
        saved   = i_rdata_o;
        flush_i = 1'b1;
        run_cycles(10);
        check("flush_rdata_kept", i_rdata_o, saved);
        @(negedge clk_i);
        i_valid_i = 1'b1; i_addr_i = 32'h0000_0200;
        run_cycles(10);

        // Randomised mixed traffic with flushes and stray acks
        ack_fixed = -1; ack_max = 3;
        i_prob = 60; d_prob = 50; flush_prob = 5; spur_prob = 5;
        run_cycles(3000);
        i_prob = 0; d_prob = 0; flush_prob = 0; spur_prob = 0;
        run_cycles(40);

        // Reset in the middle of a data access
        ack_fixed = 20;
        @(negedge clk_i);
        d_valid_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0400; d_be_i = 4'hF;
        hit = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            drive_step();
            if (m_busy && m_owner_d) begin
                hit = 1;
                break;
            end
        end
        check("wait_data_grant", hit, 1);
        run_cycles(2);
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        i_valid_i = 1'b0; d_valid_i = 1'b0; mem_ack_i = 1'b0; armed = 0;
        #1;
        check("async_rst_mem_req", mem_req_o, 0);
        check("async_rst_busy", busy_o, 0);
        check("async_rst_i_ready", i_ready_o, 0);
        check("async_rst_d_ready", d_ready_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        ack_fixed = 1;
        @(negedge clk_i);
        d_valid_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0500; d_be_i = 4'h3;
        run_cycles(12);

        check("exp_mem_drained", exp_mem.size(), 0);
        check("exp_i_drained", exp_i.size(), 0);
        check("exp_d_drained", exp_d.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single backing memory port between the instruction-fetch side (IF stage fetch requests) and the data side (MEM stage loads/stores). Serialises requests with data-side priority and a bounded anti-starvation guarantee for fetch. Supports discarding an in-flight fetch on pipeline flush. Sits between the IF/MEM stages and the memory (or cache refill) interface; the IF stage's `IMemReady_i` and the MEM stage's `DMemReady_i` are driven from this block's ready outputs.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_D_STREAK`, 4, consecutive data grants allowed while a fetch is waiting (≥1)

- `clk_i`  in  1  single clock, all state on rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `flush_i`  in  1  discard current/pending fetch
- `i_valid_i`  in  1  fetch request; held until `i_ready_o` or flush
- `i_addr_i`  in  ADDR_W  fetch address
- `i_ready_o`  out  1  one-cycle pulse: fetch complete
- `i_rdata_o`  out  DATA_W  fetched word, held until next fetch completes
- `d_valid_i`  in  1  data request; held until `d_ready_o`
- `d_we_i`  in  1  1 = store
- `d_addr_i`  in  ADDR_W  data address
- `d_wdata_i`  in  DATA_W  store data
- `d_be_i`  in  DATA_W/8  byte enables
- `d_ready_o`  out  1  one-cycle pulse: data access complete
- `d_rdata_o`  out  DATA_W  load data, held until next data completion
- `mem_req_o`  out  1  memory request, held until `mem_ack_i`
- `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_be_o`  out  1/ADDR_W/DATA_W/DATA_W/8  request payload, stable while `mem_req_o`
- `mem_ack_i`  in  1  memory completion; `mem_rdata_i` valid this cycle
- `mem_rdata_i`  in  DATA_W  read data
- `busy_o`  out  1  state ≠ IDLE

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration, combinational, for the current cycle. A requester's valid is ignored in the cycle its ready pulse is high. `i_valid_i` is ignored while `flush_i` is high.
  - If only one request is eligible, grant it.
  - If both are eligible, grant D, unless `streak == MAX_D_STREAK`; then grant I.
- On grant, the payload is latched into the `mem_*` registers and `mem_req_o` is set. The state moves to BUSY_I/BUSY_D. Fetch payload: `we=0`, `be=all ones`, `wdata=0`.
- Streak counter:
  - +1 on a D grant while `i_valid_i` is high.
  - Cleared on any I grant, and on a D grant while `i_valid_i` is low.
  - Saturates at MAX_D_STREAK.
- BUSY_x with `mem_ack_i`:
  - Clear `mem_req_o` and go to IDLE.
  - Register `mem_rdata_i` into `x_rdata_o` (stores also update `d_rdata_o`; value don't-care).
  - Pulse `x_ready_o` next cycle.
- Flush:
  - `flush_i` in BUSY_I, or on the ack cycle, sets a `drop` flag. The memory transaction still completes; on ack, `i_ready_o` is not pulsed and `i_rdata_o` is not updated. `drop` clears on ack.
  - Flush has no effect on the D side.
- Reset, including mid-transaction: state IDLE, `mem_req_o`=0 immediately (async). All outputs, rdata registers, streak and drop are 0. The memory must tolerate an abandoned request.

## Timing
- Grant in cycle N (IDLE) → `mem_req_o`=1 from N+1.
- Ack in cycle M → `mem_req_o`=0 and `x_ready_o`=1 in M+1. State is IDLE in M+1, so a new grant can occur in M+1 with `mem_req_o` high again in M+2.
- Minimum latency from valid to ready is 2 cycles (ack in the first request cycle).
- `mem_req_o` never stays high for a cycle following an ack; no two outstanding requests.
- `mem_ack_i` while IDLE is ignored.

## Structure
- Package `mem_arb_pkg`: `arb_state_t` enum (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D), `owner_t` (OWN_I, OWN_D).
- Sub-module `arb_streak_counter`: saturating counter with inc/clr/sat_o, width `$clog2(MAX_D_STREAK+1)`.
- Arbitration, FSM and payload registers stay in the top module.

## Test plan
- Lone fetch, `i_addr=0xBFC00000`, ack after 3 cycles → `mem_addr_o=0xBFC00000`, `mem_we_o=0`, single `i_ready_o` pulse, `i_rdata_o=mem_rdata_i`.
- Simultaneous I and D store (`addr=0x100`, `wdata=0xDEADBEEF`, `be=0xF`) → D served first; I granted in the cycle of `d_ready_o`.
- I held valid, D back-to-back, MAX_D_STREAK=4, 1-cycle acks → exactly 4 D grants, then I, then D resumes.
- `flush_i` during BUSY_I → memory ack consumed, no `i_ready_o`, `i_rdata_o` unchanged. A new fetch (`addr=0x200`) is then granted normally.
- `rst_i` asserted mid-BUSY_D → `mem_req_o`, `busy_o` and ready outputs go 0 without a clock edge. After release, a D request is re-granted from IDLE.
